svm_request_sequencer: RTL and testbench
========================================

// Module: svm_request_sequencer
// PURPOSE
//   Upstream driver for the SVM classifier. Gathers one sample of F_WIDTH quantized features over a serial stream.
//   Issues two classifier requests from static model ports: the valence model set, then the arousal model set.
//   Captures the returned valence/arousal pair and presents it as one label with a valid/ready handshake.
//   A watchdog stops the block hanging if the classifier never answers.
// PARAMETERS
//   NBITS          5     feature/support/alpha bit width, signed two's complement
//   VSUP_WIDTH     118   valence support-vector count
//   ASUP_WIDTH     164   arousal support-vector count
//   F_WIDTH        1     features per sample
//   SUP_WIDTH      max(VSUP_WIDTH,ASUP_WIDTH)   classifier slot count
//   LOG_SUP_WIDTH  `ceilLog2(SUP_WIDTH)
//   IW             2*NBITS+LOG_SUP_WIDTH        intercept width (18 at defaults)
//   TIMEOUT_CYCLES 1024  maximum WAIT_RES cycles before abort, >=2
// PORTS
//   clk            in   1                      clock
//   rst_n          in   1                      asynchronous reset, active low
//   feat_data      in   NBITS                  one signed feature per beat, feature 0 first
//   feat_valid     in   1                      feature beat valid
//   feat_ready     out  1                      feature beat accepted when high
//   v_support      in   NBITS*VSUP_WIDTH*F_WIDTH  valence supports, [(i*F_WIDTH+j)*NBITS +: NBITS]; static
//   v_alpha        in   NBITS*VSUP_WIDTH       valence alphas; static
//   v_intercept    in   IW                     valence intercept; static
//   a_support      in   NBITS*ASUP_WIDTH*F_WIDTH  arousal supports, same packing; static
//   a_alpha        in   NBITS*ASUP_WIDTH       arousal alphas; static
//   a_intercept    in   IW                     arousal intercept; static
//   svm_features   out  NBITS*F_WIDTH          registered features; feature f at [f*NBITS +: NBITS]
//   svm_support    out  NBITS*SUP_WIDTH*F_WIDTH  registered support set
//   svm_alpha      out  NBITS*SUP_WIDTH        registered alpha set
//   svm_intercept  out  IW                     registered intercept
//   svm_valid      out  1                      request valid
//   svm_ready      in   1                      classifier ready
//   svm_valence    in   1                      classifier valence result
//   svm_arousal    in   1                      classifier arousal result
//   svm_dout_valid in   1                      one-cycle result strobe; cannot be back-pressured
//   label_valence  out  1                      captured valence
//   label_arousal  out  1                      captured arousal
//   label_valid    out  1                      label valid
//   label_ready    in   1                      label consumer ready
//   timeout        out  1                      one-cycle pulse when a request is aborted
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous, any state):
//   - state=COLLECT, feature count=0, watchdog=0.
//   - All outputs 0, including feat_ready and every svm_* payload.
//   States:
//   - COLLECT: feat_ready=1. Each fire stores feat_data in slot cnt and increments cnt.
//     Fire at cnt=F_WIDTH-1 -> SEND_V; payload is loaded the same edge.
//   - SEND_V: svm_valid=1. Payload = features, v_support, v_alpha, v_intercept.
//     Slots VSUP_WIDTH..SUP_WIDTH-1 of support and alpha are driven 0.
//     On svm_valid&&svm_ready -> SEND_A; arousal payload loaded the same edge.
//   - SEND_A: svm_valid=1. Payload = features, a_support, a_alpha, a_intercept, zero-padded the same way.
//     On fire -> WAIT_RES, svm_valid=0, watchdog cleared.
//   - WAIT_RES: watchdog increments each cycle.
//     svm_dout_valid=1 -> capture svm_valence/svm_arousal into label_*, go to OUT.
//     Else watchdog=TIMEOUT_CYCLES-1 -> timeout=1 for one cycle, go to COLLECT, cnt=0.
//     If both happen in the same cycle, the result wins and no timeout fires.
//   - OUT: label_valid=1. Labels are held stable until label_valid&&label_ready, then COLLECT.
//     feat_ready=0 in every state except COLLECT.
//   Latency:
//   - Last feature fire at edge t -> svm_valid high from t+1.
//   - With svm_ready=1, the arousal request is presented from t+2.
//   - Result strobe at edge r -> label_valid from r+1.
//   Other rules:
//   - The svm_* payload is stable while svm_valid=1 and not yet accepted.
//   - svm_dout_valid outside WAIT_RES is ignored.
//   - Feature slots are overwritten per sample; no clearing between samples.
// TESTING
//   1 Reset mid-SEND_V, rst_n low 3 cycles -> all outputs 0 immediately; feat_ready=1 the first cycle after release.
//   2 F_WIDTH=1, feat_data=3, svm_ready=1, strobe with valence=1/arousal=0 ->
//     valence request with svm_features=3 and svm_support bits [590+:230]=0, then arousal request,
//     then label_valid=1 with labels 1/0.
//   3 svm_ready low 10 cycles in SEND_V -> svm_valid and all payload bits constant; SEND_A only after svm_ready=1.
//   4 label_ready low 5 cycles -> labels stable, feat_ready=0, feat_valid pulses ignored; COLLECT after the accept.
//   5 TIMEOUT_CYCLES=16, no strobe -> timeout pulses 16 cycles after the arousal fire.
//     Strobe on that same cycle -> label captured and timeout stays 0.
//   6 F_WIDTH=3, features -2,7,-16 with feat_valid bubbles ->
//     svm_features={5'b10000,5'b00111,5'b11110}, feature 0 at the LSBs.

Source files
------------

// File: rtl/svm_request_sequencer_if.sv
// rtl/svm_request_sequencer_if.sv - feature stream, classifier request/response and label bundle
//
// Purpose: groups the handshake and payload signals of svm_request_sequencer.
// master: the sequencer side; it drives feat_ready, the svm_* request,
//         the label_* outputs and timeout.
// slave : the environment side; it drives the feature beat, svm_ready,
//         the classifier result strobe and label_ready.
interface svm_request_sequencer_if #(
  parameter int NBITS     = 5,
  parameter int SUP_WIDTH = 164,
  parameter int F_WIDTH   = 1,
  parameter int IW        = 18
) ();
  logic [NBITS-1:0]                   feat_data;
  logic                               feat_valid;
  logic                               feat_ready;

  logic [NBITS*F_WIDTH-1:0]           svm_features;
  logic [NBITS*SUP_WIDTH*F_WIDTH-1:0] svm_support;
  logic [NBITS*SUP_WIDTH-1:0]         svm_alpha;
  logic [IW-1:0]                      svm_intercept;
  logic                               svm_valid;
  logic                               svm_ready;
  logic                               svm_valence;
  logic                               svm_arousal;
  logic                               svm_dout_valid;

  logic                               label_valence;
  logic                               label_arousal;
  logic                               label_valid;
  logic                               label_ready;
  logic                               timeout;

  modport master (
    input  feat_data, feat_valid,
    output feat_ready,
    output svm_features, svm_support, svm_alpha, svm_intercept, svm_valid,
    input  svm_ready, svm_valence, svm_arousal, svm_dout_valid,
    output label_valence, label_arousal, label_valid,
    input  label_ready,
    output timeout
  );

  modport slave (
    output feat_data, feat_valid,
    input  feat_ready,
    input  svm_features, svm_support, svm_alpha, svm_intercept, svm_valid,
    output svm_ready, svm_valence, svm_arousal, svm_dout_valid,
    input  label_valence, label_arousal, label_valid,
    output label_ready,
    input  timeout
  );
endinterface

// File: rtl/svm_request_sequencer.sv
// rtl/svm_request_sequencer.sv - gathers a feature sample, issues valence then arousal SVM requests, returns a label
//
// Purpose: collects F_WIDTH signed features from the feature stream, presents
// the valence model request and then the arousal model request to the
// classifier, captures the returned pair as one label, and aborts with a
// one-cycle timeout pulse if no result arrives within TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   v_support/v_alpha/v_intercept  static valence model
//   a_support/a_alpha/a_intercept  static arousal model
//   bus (master)          feature stream, classifier request/result, label, timeout
module svm_request_sequencer #(
  parameter int NBITS          = 5,
  parameter int VSUP_WIDTH     = 118,
  parameter int ASUP_WIDTH     = 164,
  parameter int F_WIDTH        = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SUP_WIDTH     = (VSUP_WIDTH > ASUP_WIDTH) ? VSUP_WIDTH : ASUP_WIDTH,
  localparam int LOG_SUP_WIDTH = $clog2(SUP_WIDTH),
  localparam int IW            = 2*NBITS + LOG_SUP_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NBITS*VSUP_WIDTH*F_WIDTH-1:0] v_support,
  input  logic [NBITS*VSUP_WIDTH-1:0]         v_alpha,
  input  logic [IW-1:0]                       v_intercept,
  input  logic [NBITS*ASUP_WIDTH*F_WIDTH-1:0] a_support,
  input  logic [NBITS*ASUP_WIDTH-1:0]         a_alpha,
  input  logic [IW-1:0]                       a_intercept,
  svm_request_sequencer_if.master             bus
);
  localparam int SUPP_W = NBITS*SUP_WIDTH*F_WIDTH;
  localparam int ALP_W  = NBITS*SUP_WIDTH;
  localparam int CNT_W  = (F_WIDTH > 1) ? $clog2(F_WIDTH) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F_WIDTH-1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES-1);

  typedef enum logic [2:0] {
    S_COLLECT, S_SEND_V, S_SEND_A, S_WAIT_RES, S_OUT
  } state_t;

  state_t                   state, state_d;
  logic [CNT_W-1:0]         cnt;
  logic [WD_W-1:0]          wd;
  logic [NBITS*F_WIDTH-1:0] features_q;
  logic [SUPP_W-1:0]        support_q;
  logic [ALP_W-1:0]         alpha_q;
  logic [IW-1:0]            intercept_q;
  logic                     feat_ready_q, svm_valid_q, label_valid_q, timeout_q;
  logic                     label_valence_q, label_arousal_q;

  logic feat_we, load_v, load_a, capture, abort;

  always_comb begin
    state_d = state;
    feat_we = 1'b0;
    load_v  = 1'b0;
    load_a  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      S_COLLECT: begin
        // feat_ready is registered and is still 0 in the first cycle after reset
        if (bus.feat_valid && feat_ready_q) begin
          feat_we = 1'b1;
          if (cnt == CNT_LAST) begin
            state_d = S_SEND_V;
            load_v  = 1'b1;
          end
        end
      end
      S_SEND_V: begin
        if (svm_valid_q && bus.svm_ready) begin
          state_d = S_SEND_A;
          load_a  = 1'b1;
        end
      end
      S_SEND_A: begin
        if (svm_valid_q && bus.svm_ready) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        // a result arriving on the last watchdog cycle still wins over the abort
        if (bus.svm_dout_valid) begin
          capture = 1'b1;
          state_d = S_OUT;
        end else if (wd == WD_LAST) begin
          abort   = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_OUT: begin
        if (label_valid_q && bus.label_ready) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_COLLECT;
      cnt             <= '0;
      wd              <= '0;
      features_q      <= '0;
      support_q       <= '0;
      alpha_q         <= '0;
      intercept_q     <= '0;
      feat_ready_q    <= 1'b0;
      svm_valid_q     <= 1'b0;
      label_valid_q   <= 1'b0;
      timeout_q       <= 1'b0;
      label_valence_q <= 1'b0;
      label_arousal_q <= 1'b0;
    end else begin
      state         <= state_d;
      feat_ready_q  <= (state_d == S_COLLECT);
      svm_valid_q   <= (state_d == S_SEND_V) || (state_d == S_SEND_A);
      label_valid_q <= (state_d == S_OUT);
      timeout_q     <= abort;

      if (feat_we) begin
        features_q[int'(cnt)*NBITS +: NBITS] <= bus.feat_data;
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end else if (abort) begin
        cnt <= '0;
      end

      // narrower model sets are zero-extended into the upper classifier slots
      if (load_v) begin
        support_q   <= SUPP_W'(v_support);
        alpha_q     <= ALP_W'(v_alpha);
        intercept_q <= v_intercept;
      end else if (load_a) begin
        support_q   <= SUPP_W'(a_support);
        alpha_q     <= ALP_W'(a_alpha);
        intercept_q <= a_intercept;
      end

      // the watchdog is zero on entry to WAIT_RES because it is held clear elsewhere
      if (state == S_WAIT_RES) wd <= wd + 1'b1;
      else                     wd <= '0;

      if (capture) begin
        label_valence_q <= bus.svm_valence;
        label_arousal_q <= bus.svm_arousal;
      end
    end
  end

  assign bus.feat_ready    = feat_ready_q;
  assign bus.svm_features  = features_q;
  assign bus.svm_support   = support_q;
  assign bus.svm_alpha     = alpha_q;
  assign bus.svm_intercept = intercept_q;
  assign bus.svm_valid     = svm_valid_q;
  assign bus.label_valence = label_valence_q;
  assign bus.label_arousal = label_arousal_q;
  assign bus.label_valid   = label_valid_q;
  assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_svm_request_sequencer.sv
// tb/tb_svm_request_sequencer.sv - directed self-checking bench for svm_request_sequencer
module tb_svm_request_sequencer;
  localparam int NB  = 5;
  localparam int VS  = 118;
  localparam int AS  = 164;
  localparam int SUP = 164;
  localparam int IWD = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB*VS-1:0]   v_sup0, v_alp;
  logic [NB*AS-1:0]   a_sup0, a_alp;
  logic [NB*VS*3-1:0] v_sup1;
  logic [NB*AS*3-1:0] a_sup1;
  logic [IWD-1:0]     v_int, a_int;
  logic [NB*SUP-1:0]  exp_vsup, exp_asup, exp_valp, exp_aalp;

  int n_checks = 0;
  int n_err    = 0;

  svm_request_sequencer_if #(.NBITS(NB), .SUP_WIDTH(SUP), .F_WIDTH(1), .IW(IWD)) bus0 ();
  svm_request_sequencer_if #(.NBITS(NB), .SUP_WIDTH(SUP), .F_WIDTH(3), .IW(IWD)) bus1 ();

  svm_request_sequencer #(
    .NBITS(NB), .VSUP_WIDTH(VS), .ASUP_WIDTH(AS), .F_WIDTH(1), .TIMEOUT_CYCLES(1024)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .v_support(v_sup0), .v_alpha(v_alp), .v_intercept(v_int),
    .a_support(a_sup0), .a_alpha(a_alp), .a_intercept(a_int),
    .bus(bus0)
  );

  svm_request_sequencer #(
    .NBITS(NB), .VSUP_WIDTH(VS), .ASUP_WIDTH(AS), .F_WIDTH(3), .TIMEOUT_CYCLES(16)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .v_support(v_sup1), .v_alpha(v_alp), .v_intercept(v_int),
    .a_support(a_sup1), .a_alpha(a_alp), .a_intercept(a_int),
    .bus(bus1)
  );

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_feat_ready"}, 1024'(bus0.feat_ready), 1024'(0));
    check({tag, "_svm_valid"},  1024'(bus0.svm_valid), 1024'(0));
    check({tag, "_features"},   1024'(bus0.svm_features), 1024'(0));
    check({tag, "_support"},    1024'(bus0.svm_support), 1024'(0));
    check({tag, "_alpha"},      1024'(bus0.svm_alpha), 1024'(0));
    check({tag, "_intercept"},  1024'(bus0.svm_intercept), 1024'(0));
    check({tag, "_label"},      1024'({bus0.label_valid, bus0.label_valence, bus0.label_arousal}), 1024'(0));
    check({tag, "_timeout"},    1024'(bus0.timeout), 1024'(0));
  endtask

  initial begin
    v_sup0 = {VS{5'h0B}};
    a_sup0 = {AS{5'h15}};
    v_sup1 = {(VS*3){5'h0D}};
    a_sup1 = {(AS*3){5'h13}};
    v_alp  = {VS{5'h03}};
    a_alp  = {AS{5'h1C}};
    v_int  = 18'h2ABCD;
    a_int  = 18'h1F00F;
    exp_vsup = (NB*SUP)'(v_sup0);
    exp_asup = a_sup0;
    exp_valp = (NB*SUP)'(v_alp);
    exp_aalp = a_alp;

    bus0.feat_data = '0; bus0.feat_valid = 1'b0; bus0.svm_ready = 1'b0;
    bus0.svm_valence = 1'b0; bus0.svm_arousal = 1'b0; bus0.svm_dout_valid = 1'b0;
    bus0.label_ready = 1'b0;
    bus1.feat_data = '0; bus1.feat_valid = 1'b0; bus1.svm_ready = 1'b0;
    bus1.svm_valence = 1'b0; bus1.svm_arousal = 1'b0; bus1.svm_dout_valid = 1'b0;
    bus1.label_ready = 1'b0;

    // reset state
    repeat (2) tick();
    check_zero0("reset");
    rst_n = 1'b1;
    tick();
    check("release_feat_ready", 1024'(bus0.feat_ready), 1024'(1));

    // result strobe outside WAIT_RES is ignored
    bus0.svm_dout_valid = 1'b1; bus0.svm_valence = 1'b1; bus0.svm_arousal = 1'b1;
    tick();
    bus0.svm_dout_valid = 1'b0;
    check("stray_strobe_label", 1024'({bus0.label_valid, bus0.label_valence, bus0.label_arousal}), 1024'(0));

    // single feature -> valence request
    bus0.feat_data = 5'd3; bus0.feat_valid = 1'b1;
    tick();
    bus0.feat_valid = 1'b0;
    check("v_valid", 1024'(bus0.svm_valid), 1024'(1));
    check("v_features", 1024'(bus0.svm_features), 1024'(3));
    check("v_support", 1024'(bus0.svm_support), 1024'(exp_vsup));
    check("v_support_pad", 1024'(bus0.svm_support >> 590), 1024'(0));
    check("v_alpha", 1024'(bus0.svm_alpha), 1024'(exp_valp));
    check("v_intercept", 1024'(bus0.svm_intercept), 1024'(18'h2ABCD));
    check("v_feat_ready", 1024'(bus0.feat_ready), 1024'(0));

    // back-pressure in SEND_V: request held
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 1024'(bus0.svm_valid), 1024'(1));
      check("hold_support", 1024'(bus0.svm_support), 1024'(exp_vsup));
      check("hold_alpha", 1024'(bus0.svm_alpha), 1024'(exp_valp));
      check("hold_icpt_feat", 1024'({bus0.svm_intercept, bus0.svm_features}), 1024'({18'h2ABCD, 5'd3}));
    end

    // accept valence -> arousal request
    bus0.svm_ready = 1'b1;
    tick();
    check("a_valid", 1024'(bus0.svm_valid), 1024'(1));
    check("a_support", 1024'(bus0.svm_support), 1024'(exp_asup));
    check("a_alpha", 1024'(bus0.svm_alpha), 1024'(exp_aalp));
    check("a_intercept", 1024'(bus0.svm_intercept), 1024'(18'h1F00F));
    check("a_features", 1024'(bus0.svm_features), 1024'(3));
    tick();
    bus0.svm_ready = 1'b0;
    check("wait_valid", 1024'(bus0.svm_valid), 1024'(0));

    // result -> label
    repeat (3) tick();
    bus0.svm_dout_valid = 1'b1; bus0.svm_valence = 1'b1; bus0.svm_arousal = 1'b0;
    tick();
    bus0.svm_dout_valid = 1'b0; bus0.svm_valence = 1'b0; bus0.svm_arousal = 1'b1;
    check("label_valid", 1024'(bus0.label_valid), 1024'(1));
    check("label_va", 1024'({bus0.label_valence, bus0.label_arousal}), 1024'(2'b10));
    check("label_timeout", 1024'(bus0.timeout), 1024'(0));

    // label back-pressure; feature beats ignored
    for (int i = 0; i < 5; i++) begin
      bus0.feat_valid = 1'b1; bus0.feat_data = 5'd9;
      tick();
      check("lhold_valid", 1024'(bus0.label_valid), 1024'(1));
      check("lhold_va", 1024'({bus0.label_valence, bus0.label_arousal}), 1024'(2'b10));
      check("lhold_feat_ready", 1024'(bus0.feat_ready), 1024'(0));
    end
    bus0.feat_valid = 1'b0;
    bus0.label_ready = 1'b1;
    tick();
    bus0.label_ready = 1'b0;
    check("accept_label_valid", 1024'(bus0.label_valid), 1024'(0));
    check("accept_feat_ready", 1024'(bus0.feat_ready), 1024'(1));
    check("accept_features", 1024'(bus0.svm_features), 1024'(3));

    // reset in the middle of SEND_V
    bus0.feat_data = 5'd5; bus0.feat_valid = 1'b1;
    tick();
    bus0.feat_valid = 1'b0;
    check("pre_rst_valid", 1024'(bus0.svm_valid), 1024'(1));
    check("pre_rst_features", 1024'(bus0.svm_features), 1024'(5));
    rst_n = 1'b0;
    #1;
    check_zero0("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_zero0("held_rst");
    rst_n = 1'b1;
    tick();
    check("post_rst_feat_ready", 1024'(bus0.feat_ready), 1024'(1));
    check("post_rst_svm_valid", 1024'(bus0.svm_valid), 1024'(0));

    // three features with bubbles
    bus1.feat_valid = 1'b1; bus1.feat_data = 5'b11110;
    tick();
    bus1.feat_valid = 1'b0;
    tick();
    bus1.feat_valid = 1'b1; bus1.feat_data = 5'b00111;
    tick();
    bus1.feat_valid = 1'b0;
    check("f3_not_yet", 1024'(bus1.svm_valid), 1024'(0));
    repeat (2) tick();
    bus1.feat_valid = 1'b1; bus1.feat_data = 5'b10000;
    tick();
    bus1.feat_valid = 1'b0;
    check("f3_valid", 1024'(bus1.svm_valid), 1024'(1));
    check("f3_features", 1024'(bus1.svm_features), 1024'({5'b10000, 5'b00111, 5'b11110}));
    check("f3_intercept", 1024'(bus1.svm_intercept), 1024'(18'h2ABCD));

    // timeout with no strobe
    bus1.svm_ready = 1'b1;
    tick();
    check("f3_a_intercept", 1024'(bus1.svm_intercept), 1024'(18'h1F00F));
    tick();
    bus1.svm_ready = 1'b0;
    check("to_wait_valid", 1024'(bus1.svm_valid), 1024'(0));
    for (int k = 1; k < 16; k++) begin
      tick();
      check("to_early", 1024'(bus1.timeout), 1024'(0));
    end
    tick();
    check("to_pulse", 1024'(bus1.timeout), 1024'(1));
    check("to_feat_ready", 1024'(bus1.feat_ready), 1024'(1));
    check("to_label_valid", 1024'(bus1.label_valid), 1024'(0));
    tick();
    check("to_one_cycle", 1024'(bus1.timeout), 1024'(0));

    // strobe on the last watchdog cycle wins
    bus1.feat_valid = 1'b1; bus1.feat_data = 5'd1;
    tick();
    bus1.feat_data = 5'd2;
    tick();
    bus1.feat_data = 5'd3;
    tick();
    bus1.feat_valid = 1'b0;
    check("r2_features", 1024'(bus1.svm_features), 1024'({5'd3, 5'd2, 5'd1}));
    bus1.svm_ready = 1'b1;
    repeat (2) tick();
    bus1.svm_ready = 1'b0;
    repeat (15) tick();
    bus1.svm_dout_valid = 1'b1; bus1.svm_valence = 1'b0; bus1.svm_arousal = 1'b1;
    tick();
    bus1.svm_dout_valid = 1'b0;
    check("race_timeout", 1024'(bus1.timeout), 1024'(0));
    check("race_label_valid", 1024'(bus1.label_valid), 1024'(1));
    check("race_label_va", 1024'({bus1.label_valence, bus1.label_arousal}), 1024'(2'b01));
    tick();
    check("race_timeout_after", 1024'(bus1.timeout), 1024'(0));
    bus1.label_ready = 1'b1;
    tick();
    bus1.label_ready = 1'b0;
    check("race_accept_valid", 1024'(bus1.label_valid), 1024'(0));
    check("race_accept_ready", 1024'(bus1.feat_ready), 1024'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
